// File: rtl/ghash_ctrl.sv
// ghash_ctrl: GHASH chain controller for AES-GCM authentication.
// Folds AAD/ciphertext blocks into a running accumulator through an external
// GF(2^128) multiplier, then hashes the len(A)||len(C) block and reports the
// final GHASH value.
module ghash_ctrl (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iStart,
  input  logic [127:0] iHashkey,
  input  logic         iHashkey_valid,
  input  logic [127:0] iBlock,
  input  logic         iBlock_valid,
  output logic         oBlock_ready,
  input  logic         iBlock_is_aad,
  input  logic [4:0]   iBlock_bytes,
  input  logic         iBlock_last,
  output logic         oMul_next,
  output logic [127:0] oMul_ctext,
  output logic         oMul_ctext_valid,
  output logic [127:0] oMul_hashkey,
  output logic         oMul_hashkey_valid,
  input  logic [127:0] iMul_result,
  input  logic         iMul_result_valid,
  output logic [127:0] oGhash,
  output logic         oGhash_valid,
  output logic         oBusy,
  output logic         oError
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_LEN    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]   state_q, state_d;
  logic [127:0] acc_q, acc_d;
  logic [127:0] x_q, x_d;
  logic [127:0] h_q, h_d;
  logic [127:0] ghash_q, ghash_d;
  logic [63:0]  aad_len_q, aad_len_d;
  logic [63:0]  c_len_q, c_len_d;
  logic         last_q, last_d;
  logic         len_done_q, len_done_d;
  logic         seen_low_q, seen_low_d;
  logic         seen_ct_q, seen_ct_d;
  logic         err_q, err_d;

  logic [4:0]   blk_bytes_s;
  logic [63:0]  blk_bits_s;
  logic [127:0] blk_masked_s;

  // Zero every byte whose index is at or beyond the valid byte count.
  function automatic logic [127:0] mask_block(input logic [127:0] blk,
                                              input logic [4:0]   nbytes);
    logic [127:0] keep;
    keep = 128'd0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nbytes) begin
        keep[127-8*i -: 8] = 8'hFF;
      end else begin
        keep[127-8*i -: 8] = 8'h00;
      end
    end
    return blk & keep;
  endfunction

  // Clamp the byte count, derive the bit length and the masked block.
  always_comb begin
    if (iBlock_bytes > 5'd16) begin
      blk_bytes_s = 5'd16;
    end else begin
      blk_bytes_s = iBlock_bytes;
    end
    blk_bits_s   = {56'd0, blk_bytes_s, 3'b000};
    blk_masked_s = mask_block(iBlock, blk_bytes_s);
  end

  // Next-state and datapath update for the GHASH sequencing FSM.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    x_d        = x_q;
    h_d        = h_q;
    ghash_d    = ghash_q;
    aad_len_d  = aad_len_q;
    c_len_d    = c_len_q;
    last_d     = last_q;
    len_done_d = len_done_q;
    seen_low_d = seen_low_q;
    seen_ct_d  = seen_ct_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (iStart && iHashkey_valid) begin
          acc_d      = 128'd0;
          aad_len_d  = 64'd0;
          c_len_d    = 64'd0;
          last_d     = 1'b0;
          len_done_d = 1'b0;
          seen_ct_d  = 1'b0;
          err_d      = 1'b0;
          ghash_d    = 128'd0;
          h_d        = iHashkey;
          state_d    = S_ACCEPT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCEPT: begin
        if (iBlock_valid) begin
          if (iBlock_is_aad) begin
            aad_len_d = aad_len_q + blk_bits_s;
            // AAD after ciphertext is an ordering fault, but still hashed as AAD.
            err_d     = err_q | seen_ct_q;
          end else begin
            c_len_d   = c_len_q + blk_bits_s;
            seen_ct_d = 1'b1;
          end
          last_d = iBlock_last;
          if ((iBlock_bytes == 5'd0) && iBlock_last) begin
            // Empty end-of-message marker: nothing to multiply.
            state_d = S_LEN;
          end else begin
            x_d     = acc_q ^ blk_masked_s;
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_ISSUE: begin
        seen_low_d = 1'b0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A valid level only counts once it has been seen low after the
        // request, so a level left over from the last multiply is ignored.
        if (iMul_result_valid && seen_low_q) begin
          acc_d = iMul_result;
          if (len_done_q) begin
            ghash_d = iMul_result;
            state_d = S_DONE;
          end else if (last_q) begin
            state_d = S_LEN;
          end else begin
            state_d = S_ACCEPT;
          end
        end else if (!iMul_result_valid) begin
          seen_low_d = 1'b1;
        end else begin
          seen_low_d = seen_low_q;
        end
      end
      S_LEN: begin
        x_d        = acc_q ^ {aad_len_q, c_len_q};
        len_done_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= S_IDLE;
      acc_q      <= 128'd0;
      x_q        <= 128'd0;
      h_q        <= 128'd0;
      ghash_q    <= 128'd0;
      aad_len_q  <= 64'd0;
      c_len_q    <= 64'd0;
      last_q     <= 1'b0;
      len_done_q <= 1'b0;
      seen_low_q <= 1'b0;
      seen_ct_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      h_q        <= h_d;
      ghash_q    <= ghash_d;
      aad_len_q  <= aad_len_d;
      c_len_q    <= c_len_d;
      last_q     <= last_d;
      len_done_q <= len_done_d;
      seen_low_q <= seen_low_d;
      seen_ct_q  <= seen_ct_d;
      err_q      <= err_d;
    end
  end

  // Status and handshake outputs decoded from the state register only.
  always_comb begin
    oBlock_ready       = (state_q == S_ACCEPT);
    oMul_next          = (state_q == S_ISSUE);
    oMul_ctext_valid   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    oMul_hashkey_valid = (state_q == S_ACCEPT) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT)   || (state_q == S_LEN);
    oGhash_valid       = (state_q == S_DONE);
    oBusy              = (state_q != S_IDLE);
    oMul_ctext         = x_q;
    oMul_hashkey       = h_q;
    oGhash             = ghash_q;
    oError             = err_q;
  end

endmodule

// File: tb/tb_ghash_ctrl.sv
// tb_ghash_ctrl: self-checking bench for ghash_ctrl with a GF(2^128)
// multiplier responder and a message-level GHASH reference model.
module tb_ghash_ctrl;

  logic         iClk;
  logic         iRst;
  logic         iStart;
  logic [127:0] iHashkey;
  logic         iHashkey_valid;
  logic [127:0] iBlock;
  logic         iBlock_valid;
  logic         oBlock_ready;
  logic         iBlock_is_aad;
  logic [4:0]   iBlock_bytes;
  logic         iBlock_last;
  logic         oMul_next;
  logic [127:0] oMul_ctext;
  logic         oMul_ctext_valid;
  logic [127:0] oMul_hashkey;
  logic         oMul_hashkey_valid;
  logic [127:0] iMul_result;
  logic         iMul_result_valid;
  logic [127:0] oGhash;
  logic         oGhash_valid;
  logic         oBusy;
  logic         oError;

  ghash_ctrl dut (
    .iClk(iClk), .iRst(iRst), .iStart(iStart),
    .iHashkey(iHashkey), .iHashkey_valid(iHashkey_valid),
    .iBlock(iBlock), .iBlock_valid(iBlock_valid), .oBlock_ready(oBlock_ready),
    .iBlock_is_aad(iBlock_is_aad), .iBlock_bytes(iBlock_bytes), .iBlock_last(iBlock_last),
    .oMul_next(oMul_next), .oMul_ctext(oMul_ctext), .oMul_ctext_valid(oMul_ctext_valid),
    .oMul_hashkey(oMul_hashkey), .oMul_hashkey_valid(oMul_hashkey_valid),
    .iMul_result(iMul_result), .iMul_result_valid(iMul_result_valid),
    .oGhash(oGhash), .oGhash_valid(oGhash_valid), .oBusy(oBusy), .oError(oError)
  );

  typedef struct {
    logic [127:0] data;
    logic [4:0]   nb;
    logic         aad;
    logic         last;
  } blk_t;

  blk_t         msg[$];
  logic [127:0] ctext_log[$];
  logic [127:0] exp_ctext[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           pulse_cnt = 0;
  logic [127:0] ghash_seen;
  logic         err_at_done;
  int           mul_lat;
  logic         stale_mode;
  int           stale_hold;

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // GF(2^128) product in the GCM bit order (bit 0 of a block is the MSB).
  function automatic logic [127:0] gfmul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = 128'd0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'hE1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  // Keep the first n bytes of a left-aligned block.
  function automatic logic [127:0] model_mask(input logic [127:0] d, input int n);
    logic [127:0] keep;
    keep = ~((128'd1 << (128 - 8 * n)) - 128'd1);
    return d & keep;
  endfunction

  // Reference GHASH of the queued message: expected multiplier operands, result, error.
  task automatic model_msg(input logic [127:0] h, output logic [127:0] g, output logic e);
    logic [127:0] acc, x;
    logic [63:0]  la, lc;
    logic         seen_ct;
    int           n;
    exp_ctext.delete();
    acc = 128'd0; la = 64'd0; lc = 64'd0; e = 1'b0; seen_ct = 1'b0;
    foreach (msg[k]) begin
      n = (msg[k].nb > 5'd16) ? 16 : int'(msg[k].nb);
      if (msg[k].aad) begin
        la = la + 64'(8 * n);
        if (seen_ct) e = 1'b1;
      end else begin
        lc = lc + 64'(8 * n);
        seen_ct = 1'b1;
      end
      if (!(msg[k].nb == 5'd0 && msg[k].last)) begin
        x = acc ^ model_mask(msg[k].data, n);
        exp_ctext.push_back(x);
        acc = gfmul(x, h);
      end
    end
    x = acc ^ {la, lc};
    exp_ctext.push_back(x);
    g = gfmul(x, h);
  endtask

  task automatic add_blk(input logic [127:0] d, input logic [4:0] nb, input logic aad, input logic last);
    blk_t b;
    b.data = d; b.nb = nb; b.aad = aad; b.last = last;
    msg.push_back(b);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Multiplier responder: answers each request after mul_lat cycles,
  // optionally holding a stale valid level with a bogus product first.
  initial begin
    logic [127:0] cap_x, cap_h;
    iMul_result = 128'd0;
    iMul_result_valid = 1'b0;
    forever begin
      @(posedge iClk); #1;
      if (oMul_next === 1'b1) begin
        cap_x = oMul_ctext;
        cap_h = oMul_hashkey;
        ctext_log.push_back(cap_x);
        if (stale_mode) begin
          iMul_result = 128'hBADBADBADBADBADBADBADBADBADBADBA;
          iMul_result_valid = 1'b1;
          for (int s = 0; s < stale_hold; s++) begin @(posedge iClk); #1; end
        end
        iMul_result_valid = 1'b0;
        for (int w = 0; w < mul_lat; w++) begin @(posedge iClk); #1; end
        iMul_result = gfmul(cap_x, cap_h);
        iMul_result_valid = 1'b1;
      end
    end
  end

  // Records every final-value pulse.
  always @(negedge iClk) begin
    if (oGhash_valid === 1'b1) begin
      pulse_cnt = pulse_cnt + 1;
      ghash_seen = oGhash;
      err_at_done = oError;
    end
  end

  // Start a GHASH with key h, feed the queued message, wait for the result.
  task automatic drive_msg(input logic [127:0] h, output logic tmo,
                           output logic err_after_start, output logic [127:0] ghash_after_start);
    int budget;
    tmo = 1'b0;
    ctext_log.delete();
    pulse_cnt = 0;
    @(negedge iClk);
    iHashkey = h; iHashkey_valid = 1'b1; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0; iHashkey_valid = 1'b0;
    err_after_start = oError;
    ghash_after_start = oGhash;
    foreach (msg[k]) begin
      iBlock = msg[k].data; iBlock_bytes = msg[k].nb;
      iBlock_is_aad = msg[k].aad; iBlock_last = msg[k].last; iBlock_valid = 1'b1;
      budget = 0;
      while (oBlock_ready !== 1'b1 && budget < 200) begin @(negedge iClk); budget++; end
      if (budget >= 200) tmo = 1'b1;
      @(negedge iClk);
      iBlock_valid = 1'b0;
    end
    budget = 0;
    while (pulse_cnt == 0 && budget < 400) begin @(negedge iClk); budget++; end
    if (pulse_cnt == 0) tmo = 1'b1;
    repeat (3) @(negedge iClk);
  endtask

  task automatic test_reset();
    iRst = 1'b1;
    repeat (3) @(negedge iClk);
    n_checks++;
    if ({oBusy, oBlock_ready, oMul_next, oMul_ctext_valid, oMul_hashkey_valid, oGhash_valid, oError} !== 7'd0 ||
        oMul_ctext !== 128'd0 || oMul_hashkey !== 128'd0 || oGhash !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b rdy=%b next=%b cv=%b hv=%b gv=%b err=%b ctext=%h hk=%h ghash=%h, required all zero",
               oBusy, oBlock_ready, oMul_next, oMul_ctext_valid, oMul_hashkey_valid, oGhash_valid, oError,
               oMul_ctext, oMul_hashkey, oGhash);
    end
    iRst = 1'b0;
    @(negedge iClk);
    iStart = 1'b1; iHashkey_valid = 1'b0;
    @(negedge iClk);
    iStart = 1'b0;
    n_checks++;
    if (oBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_without_key: busy=%b, required 0", oBusy);
    end
  endtask

  task automatic test_empty();
    logic tmo, ea; logic [127:0] ga, g; logic e;
    msg.delete();
    add_blk(rand128(), 5'd0, 1'b0, 1'b1);
    model_msg(128'h66E94BD4EF8A2C3B884CFA59CA342B2E, g, e);
    drive_msg(128'h66E94BD4EF8A2C3B884CFA59CA342B2E, tmo, ea, ga);
    n_checks++;
    if (tmo) begin n_fail++; $display("FAIL empty_timeout: no result, required one pulse"); end
    n_checks++;
    if (ctext_log.size() !== 1) begin
      n_fail++; $display("FAIL empty_mul_count: got %0d multiplies, required 1", ctext_log.size());
    end else if (ctext_log[0] !== 128'd0) begin
      n_fail++; $display("FAIL empty_ctext: got %h, required 0", ctext_log[0]);
    end
    n_checks++;
    if (pulse_cnt !== 1 || ghash_seen !== 128'd0) begin
      n_fail++; $display("FAIL empty_ghash: pulses=%0d ghash=%h, required 1 pulse of 0", pulse_cnt, ghash_seen);
    end
  endtask

  task automatic test_single_ct();
    logic tmo, ea; logic [127:0] ga, g; logic e;
    logic [127:0] h;
    h = 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    msg.delete();
    add_blk(128'h0388DACE60B6A392F328C2B971B2FE78, 5'd16, 1'b0, 1'b1);
    model_msg(h, g, e);
    mul_lat = 3;
    drive_msg(h, tmo, ea, ga);
    n_checks++;
    if (tmo || ctext_log.size() !== 2) begin
      n_fail++; $display("FAIL single_count: tmo=%b multiplies=%0d, required 2", tmo, ctext_log.size());
    end else begin
      n_checks++;
      if (ctext_log[0] !== 128'h0388DACE60B6A392F328C2B971B2FE78) begin
        n_fail++; $display("FAIL single_ctext0: got %h, required 0388DACE60B6A392F328C2B971B2FE78", ctext_log[0]);
      end
      n_checks++;
      if (ctext_log[1] !== 128'h5E2EC746917062882C85B0685353DE37) begin
        n_fail++; $display("FAIL single_len_ctext: got %h, required 5E2EC746917062882C85B0685353DE37", ctext_log[1]);
      end
    end
    n_checks++;
    if (pulse_cnt !== 1 || ghash_seen !== g) begin
      n_fail++; $display("FAIL single_ghash: pulses=%0d got %h, required 1 pulse of %h", pulse_cnt, ghash_seen, g);
    end
    n_checks++;
    if (oGhash !== g || oBusy !== 1'b0) begin
      n_fail++; $display("FAIL single_hold: oGhash=%h busy=%b, required %h idle", oGhash, oBusy, g);
    end
  endtask

  task automatic test_aad_chain();
    logic tmo, ea; logic [127:0] ga, g; logic e;
    logic [127:0] h, r1, b2m, acc2;
    h = 128'h73A23D80121DE2D5A850253FCF43120E;
    r1 = 128'h9CABBD91899C1413AA7AD629C1DF12CD;
    b2m = 128'hB2C2846512153524C0895E8100000000;
    msg.delete();
    add_blk(128'hD609B1F056637A0D46DF998D88E52E00, 5'd16, 1'b1, 1'b0);
    add_blk(128'hB2C2846512153524C0895E81DEADBEEF, 5'd12, 1'b1, 1'b1);
    model_msg(h, g, e);
    mul_lat = 2;
    drive_msg(h, tmo, ea, ga);
    n_checks++;
    if (tmo || ctext_log.size() !== 3) begin
      n_fail++; $display("FAIL aad_count: tmo=%b multiplies=%0d, required 3", tmo, ctext_log.size());
    end else begin
      n_checks++;
      if (ctext_log[1] !== (r1 ^ b2m)) begin
        n_fail++; $display("FAIL aad_partial_ctext: got %h, required %h", ctext_log[1], r1 ^ b2m);
      end
      acc2 = gfmul(exp_ctext[1], h);
      n_checks++;
      if ((ctext_log[2] ^ acc2) !== {64'hE0, 64'h0}) begin
        n_fail++; $display("FAIL aad_len_block: lengths %h, required %h", ctext_log[2] ^ acc2, {64'hE0, 64'h0});
      end
    end
    n_checks++;
    if (ghash_seen !== g || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL aad_ghash: got %h err=%b, required %h err=0", ghash_seen, err_at_done, g);
    end
  endtask

  task automatic test_stale_valid();
    logic tmo, ea; logic [127:0] ga, g, h; logic e;
    h = rand128();
    msg.delete();
    add_blk(rand128(), 5'd16, 1'b0, 1'b0);
    add_blk(rand128(), 5'd9, 1'b0, 1'b1);
    model_msg(h, g, e);
    stale_mode = 1'b1; stale_hold = 3; mul_lat = 2;
    drive_msg(h, tmo, ea, ga);
    stale_mode = 1'b0;
    n_checks++;
    if (tmo || ctext_log.size() !== exp_ctext.size()) begin
      n_fail++; $display("FAIL stale_count: tmo=%b multiplies=%0d, required %0d", tmo, ctext_log.size(), exp_ctext.size());
    end else begin
      foreach (exp_ctext[k]) begin
        n_checks++;
        if (ctext_log[k] !== exp_ctext[k]) begin
          n_fail++; $display("FAIL stale_ctext%0d: got %h, required %h", k, ctext_log[k], exp_ctext[k]);
        end
      end
    end
    n_checks++;
    if (pulse_cnt !== 1 || ghash_seen !== g) begin
      n_fail++; $display("FAIL stale_ghash: pulses=%0d got %h, required %h", pulse_cnt, ghash_seen, g);
    end
  endtask

  task automatic test_order_error();
    logic tmo, ea; logic [127:0] ga, g, h; logic e;
    h = rand128();
    msg.delete();
    add_blk(rand128(), 5'd16, 1'b0, 1'b0);
    add_blk(rand128(), 5'd8, 1'b1, 1'b1);
    model_msg(h, g, e);
    mul_lat = 2;
    drive_msg(h, tmo, ea, ga);
    n_checks++;
    if (tmo || err_at_done !== e || ghash_seen !== g) begin
      n_fail++; $display("FAIL order_done: tmo=%b err=%b ghash=%h, required err=%b ghash=%h", tmo, err_at_done, ghash_seen, e, g);
    end
    n_checks++;
    if (oError !== 1'b1) begin
      n_fail++; $display("FAIL order_sticky: oError=%b in idle, required 1", oError);
    end
    msg.delete();
    add_blk(rand128(), 5'd16, 1'b1, 1'b1);
    model_msg(h, g, e);
    drive_msg(h, tmo, ea, ga);
    n_checks++;
    if (ea !== 1'b0 || ga !== 128'd0) begin
      n_fail++; $display("FAIL order_clear: oError=%b oGhash=%h after start, required 0 and 0", ea, ga);
    end
    n_checks++;
    if (tmo || ghash_seen !== g || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL order_next_msg: got %h err=%b, required %h err=0", ghash_seen, err_at_done, g);
    end
  endtask

  task automatic test_random();
    logic tmo, ea; logic [127:0] ga, g, h; logic e;
    int na, nc, tot, idx;
    for (int r = 0; r < 8; r++) begin
      h = rand128();
      na = $urandom_range(0, 2);
      nc = $urandom_range(0, 2);
      if (r == 5) begin na = 1; nc = 1; end
      tot = na + nc;
      msg.delete();
      idx = 0;
      for (int a = 0; a < na; a++) begin
        idx++;
        add_blk(rand128(), 5'($urandom_range(0, 20)), 1'b1, (idx == tot && r != 5));
      end
      for (int c = 0; c < nc; c++) begin
        idx++;
        add_blk(rand128(), 5'($urandom_range(0, 20)), 1'b0, (idx == tot && r != 5));
      end
      if (tot == 0 || r == 5) add_blk(rand128(), 5'd0, ($urandom_range(0, 1) == 1), 1'b1);
      if (r == 3) msg.push_back(msg[0]);
      if (r == 3) begin
        foreach (msg[k]) msg[k].last = (k == msg.size() - 1);
      end
      model_msg(h, g, e);
      mul_lat = $urandom_range(2, 5);
      drive_msg(h, tmo, ea, ga);
      n_checks++;
      if (tmo || ctext_log.size() !== exp_ctext.size()) begin
        n_fail++; $display("FAIL rand%0d_count: tmo=%b multiplies=%0d, required %0d", r, tmo, ctext_log.size(), exp_ctext.size());
      end else begin
        foreach (exp_ctext[k]) begin
          n_checks++;
          if (ctext_log[k] !== exp_ctext[k]) begin
            n_fail++; $display("FAIL rand%0d_ctext%0d: got %h, required %h", r, k, ctext_log[k], exp_ctext[k]);
          end
        end
      end
      n_checks++;
      if (pulse_cnt !== 1 || ghash_seen !== g || err_at_done !== e) begin
        n_fail++; $display("FAIL rand%0d_ghash: pulses=%0d got %h err=%b, required %h err=%b", r, pulse_cnt, ghash_seen, err_at_done, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int budget;
    mul_lat = 8;
    ctext_log.delete();
    @(negedge iClk);
    iHashkey = rand128(); iHashkey_valid = 1'b1; iStart = 1'b1;
    @(negedge iClk);
    iStart = 1'b0; iHashkey_valid = 1'b0;
    iBlock = rand128(); iBlock_bytes = 5'd16; iBlock_is_aad = 1'b0; iBlock_last = 1'b1; iBlock_valid = 1'b1;
    @(negedge iClk);
    iBlock_valid = 1'b0;
    budget = 0;
    while (ctext_log.size() == 0 && budget < 20) begin @(negedge iClk); budget++; end
    @(negedge iClk);
    n_checks++;
    if (oMul_ctext_valid !== 1'b1 || oBusy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_wait: ctext_valid=%b busy=%b, required 1 1", oMul_ctext_valid, oBusy);
    end
    pulse_cnt = 0;
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    n_checks++;
    if ({oBusy, oBlock_ready, oMul_next, oMul_ctext_valid, oMul_hashkey_valid, oGhash_valid, oError} !== 7'd0 ||
        oMul_ctext !== 128'd0 || oMul_hashkey !== 128'd0) begin
      n_fail++; $display("FAIL rst_mid_wait: busy=%b next=%b cv=%b hv=%b ctext=%h, required all zero",
                         oBusy, oMul_next, oMul_ctext_valid, oMul_hashkey_valid, oMul_ctext);
    end
    repeat (15) @(negedge iClk);
    n_checks++;
    if (pulse_cnt !== 0 || oBusy !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_result: pulses=%0d busy=%b, required 0 0", pulse_cnt, oBusy);
    end
  endtask

  initial begin
    iRst = 1'b1; iStart = 1'b0; iHashkey = 128'd0; iHashkey_valid = 1'b0;
    iBlock = 128'd0; iBlock_valid = 1'b0; iBlock_is_aad = 1'b0; iBlock_bytes = 5'd0; iBlock_last = 1'b0;
    mul_lat = 2; stale_mode = 1'b0; stale_hold = 3;
    test_reset();
    test_empty();
    test_single_ct();
    test_aad_chain();
    test_stale_valid();
    test_order_error();
    test_random();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ghash_ctrl.md
# ghash_ctrl

Drives the GHASH chain for AES-GCM authentication by acting as the initiator on the gfmul_v2 multiplier interface. It accepts a stream of 128-bit AAD and ciphertext blocks and XORs each block into the running accumulator. For each block it issues one multiply against the hash key H. After the last data block it builds and hashes the len(A)||len(C) block itself, then presents the final GHASH value to the tag stage.

## Interface
- No parameters. Block width is fixed at 128 and the length counters at 64 bits.
- iClk  in  1  clock
- iRst  in  1  synchronous, active-high reset
- iStart  in  1  pulse; begins a new GHASH; honoured only in IDLE
- iHashkey  in  128  H; latched at an accepted iStart
- iHashkey_valid  in  1  iStart is ignored unless this is high
- iBlock  in  128  data block; bytes are left-aligned (byte 0 is bits 127:120)
- iBlock_valid  in  1  block offered
- oBlock_ready  out  1  block accepted when iBlock_valid && oBlock_ready
- iBlock_is_aad  in  1  1 = AAD block, 0 = ciphertext block
- iBlock_bytes  in  5  valid bytes, 0..16; values above 16 are treated as 16
- iBlock_last  in  1  final data block of the message
- oMul_next  out  1  one-cycle multiply request
- oMul_ctext  out  128  X = acc ^ block; held stable from ISSUE until completion
- oMul_ctext_valid  out  1  high in ISSUE and WAIT
- oMul_hashkey  out  128  latched H
- oMul_hashkey_valid  out  1  high from an accepted iStart until DONE
- iMul_result  in  128  multiplier product
- iMul_result_valid  in  1  multiplier done level
- oGhash  out  128  final accumulator value
- oGhash_valid  out  1  one-cycle pulse
- oBusy  out  1  high in every state except IDLE
- oError  out  1  sticky ordering error; cleared at iStart

## Operation
- States: IDLE, ACCEPT, ISSUE, WAIT, LEN, DONE.
- IDLE
  - iStart && iHashkey_valid: acc=0, aad_len=0, c_len=0, len_done=0, oError=0, latch H; go to ACCEPT.
  - iStart with iHashkey_valid low is ignored.
- ACCEPT
  - oBlock_ready=1. On a handshake:
  - Mask bytes at index ≥ iBlock_bytes to 0.
  - Add iBlock_bytes×8 to aad_len if iBlock_is_aad, else to c_len. Both counters wrap modulo 2^64.
  - Record iBlock_last.
  - If iBlock_bytes==0 and iBlock_last=1 (empty marker): no multiply; go to LEN.
  - Else X=acc^masked block; go to ISSUE.
  - An AAD block accepted after any ciphertext block sets oError. The block is still processed and counted as AAD.
- ISSUE
  - oMul_next=1 for exactly this cycle.
  - Clear flag seen_low; go to WAIT.
- WAIT
  - Set seen_low when iMul_result_valid is observed low.
  - Completion: iMul_result_valid high with seen_low already set. This rejects a stale valid level left over from the previous multiply.
  - On completion, acc=iMul_result, then:
    - if len_done, go to DONE;
    - else if last recorded, go to LEN;
    - else go to ACCEPT.
- LEN
  - X = acc ^ {aad_len, c_len}; len_done=1; go to ISSUE.
- DONE
  - oGhash=acc; oGhash_valid=1 for one cycle; go to IDLE.
  - oGhash holds its value until the next accepted iStart or a reset.

## Timing
- Reset values: all outputs 0; state=IDLE; acc, H and length counters cleared.
- Reset asserted mid-operation aborts immediately: oMul_next=0, oMul_ctext_valid=0. A multiplier result arriving later is ignored.
- Per data block: 1 cycle ACCEPT, 1 cycle ISSUE, then M+1 cycles in WAIT (M = multiplier latency).
- Length block: 1 cycle LEN, then ISSUE and WAIT as above.
- DONE adds 1 cycle. oGhash_valid asserts the cycle after the length-block completion.
- oBlock_ready is combinational from state only; it does not depend on iBlock_valid.
- iStart outside IDLE is ignored, including in DONE.
- iBlock_valid is ignored outside ACCEPT.

## Test plan
- Empty message
  - Stimulus: H=66E94BD4EF8A2C3B884CFA59CA342B2E; iStart; empty marker (bytes=0, last=1).
  - Required: exactly one multiply, with oMul_ctext=0. Model returns 0 → oGhash=0, one oGhash_valid pulse.
- Single ciphertext block
  - Stimulus: same H; block 0388DACE60B6A392F328C2B971B2FE78, bytes=16, last=1.
  - Required: first oMul_ctext equals the block. Model returns 5E2EC746917062882C85B0685353DEB7.
  - Required: second oMul_ctext = 5E2EC746917062882C85B0685353DE37 (c_len=0x80).
- AAD chaining with a partial block
  - Stimulus: H=73A23D80121DE2D5A850253FCF43120E.
    - AAD D609B1F056637A0D46DF998D88E52E00 (16 bytes), model result 9CABBD91899C1413AA7AD629C1DF12CD.
    - AAD B2C2846512153524C0895E81DEADBEEF (12 bytes).
  - Required: second oMul_ctext = 9CABBD91899C1413AA7AD629C1DF12CD ^ B2C2846512153524C0895E8100000000, so the low 4 bytes are masked.
  - Required: length block has aad_len=0xE0.
- Stale valid
  - Stimulus: model holds iMul_result_valid high across oMul_next.
  - Required: the controller stays in WAIT until the valid level drops and rises again; no early capture.
- Ordering error
  - Stimulus: ciphertext block, then an AAD block.
  - Required: oError=1 and stays set through DONE; it clears at the next iStart.
- Reset mid-WAIT
  - Stimulus: iRst=1 for one cycle during WAIT.
  - Required: all outputs 0 the next cycle and oBusy=0. A late iMul_result_valid causes no oGhash_valid.
